// File: rtl/inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_seq
//   Sequential InvSubBytes stage of the AES-128 decryption round. Takes the
//   128-bit state from InvShiftRows, replaces every byte with InvSbox(byte)
//   BYTES_PER_CYCLE bytes per clock, and hands the result to AddRoundKey.
//   Area and throughput are traded through BYTES_PER_CYCLE (1,2,4,8,16).
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    in_state valid
//   in_ready   out  1    stage can accept in_state this cycle
//   in_state   in   128  byte i = in_state[8*i +: 8]
//   out_valid  out  1    out_state holds a complete substituted state
//   out_ready  in   1    downstream accepts out_state this cycle
//   out_state  out  128  byte i = out_state[8*i +: 8]
//
// Timing: the accept edge is followed by N = 16/BYTES_PER_CYCLE substitution
// passes plus one cycle to register the result, so out_valid rises exactly
// N+1 clocks after the accept edge.
// ---------------------------------------------------------------------------
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry i = InvSbox(i).
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    work_q;
  logic [127:0]    work_d;
  logic [127:0]    out_state_q;
  logic            out_valid_q;

  logic [3:0]      lane_idx [BYTES_PER_CYCLE];
  logic [7:0]      lane_out [BYTES_PER_CYCLE];

  // One inverse S-box per lane. Lane l handles byte cnt*B + l; the 4-bit
  // truncation only aliases on the final (cnt == N) cycle, when nothing is
  // written back.
  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    assign lane_idx[l] = 4'(int'(cnt_q) * BYTES_PER_CYCLE + l);
    assign lane_out[l] = INV_SBOX[work_q[{lane_idx[l], 3'b000} +: 8]];
  end

  // Work register with the current pass's bytes replaced in place.
  always_comb begin
    // NOTE: start from a full default so every path assigns work_d and no latch is inferred.
    work_d = work_q;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      work_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
    end
  end

  // DONE forwards out_ready so a new state can be taken on the same edge
  // that the finished one is consumed.
  assign in_ready  = !rst && ((state_q == IDLE) || (state_q == DONE && out_ready));
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_state;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end

        BUSY: begin
          if (cnt_q == CW'(N)) begin
            // All N passes are in work_q; publish it.
            out_state_q <= work_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              work_q  <= in_state;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_bytes_seq
//   Self-checking bench for inv_sub_bytes_seq. One instance per legal
//   BYTES_PER_CYCLE (1,2,4,8,16) on a shared clock and reset. Expected data
//   comes from an inverse S-box derived arithmetically (GF(2^8) inverse plus
//   the forward affine map, then inverted), plus hand-computed constants.
// ---------------------------------------------------------------------------
module tb_inv_sub_bytes_seq;

  localparam int NI = 5;
  localparam int BS [NI] = '{1, 2, 4, 8, 16};

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [NI];
  logic         ir   [NI];
  logic [127:0] ist  [NI];
  logic         ov   [NI];
  logic         ordy [NI];
  logic [127:0] ost  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] inv_tbl [256];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_state  (ist[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_state (ost[g])
    );
  end

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] s;
    s = ginv(x);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[st[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sends one state to instance k, waits for the result and consumes it.
  task automatic run_one(input int k, input logic [127:0] st, input string tag,
                         output logic [127:0] res);
    int guard;
    int lat;
    iv[k] = 1'b1; ist[k] = st; ordy[k] = 1'b0;
    guard = 0;
    while (!ir[k] && guard < 50) begin @(posedge clk); #1; guard++; end
    check({tag, "_rdy"}, ir[k], 1'b1);
    @(posedge clk); #1;                         // accept edge
    iv[k] = 1'b0; ist[k] = ~st;                 // ignored while busy
    lat = 0;
    while (!ov[k] && lat < 40) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, lat, 16 / BS[k] + 1);
    res = ost[k];
    check({tag, "_data"}, res, model(st));
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    check({tag, "_drop"}, ov[k], 1'b0);
    check({tag, "_idle"}, ir[k], 1'b1);
  endtask

  // in_valid held high with out_ready=1: every state must come back once,
  // in order, N+1 clocks after it was accepted.
  task automatic b2b(input int k, input string tag);
    logic [127:0] vec [4];
    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           idx, got, cyc, acc_cyc;
    logic         accept;
    for (int i = 0; i < 4; i++) vec[i] = rand128();
    idx = 0; got = 0; cyc = 0;
    ordy[k] = 1'b1; iv[k] = 1'b1; ist[k] = vec[0];
    while (got < 4 && cyc < 400) begin
      if (ov[k]) begin
        check({tag, "_qnonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          acc_cyc = acc_q.pop_front();
          check({tag, "_data"}, ost[k], exp_q.pop_front());
          check({tag, "_lat"}, cyc - acc_cyc, 16 / BS[k] + 1);
        end
        got++;
      end
      accept = iv[k] && ir[k];
      if (accept) begin
        exp_q.push_back(model(vec[idx]));
        acc_q.push_back(cyc + 1);
      end
      @(posedge clk); #1; cyc++;
      if (accept) begin
        idx++;
        if (idx < 4) ist[k] = vec[idx];
        else iv[k] = 1'b0;
      end
    end
    check({tag, "_count"}, got, 4);
    check({tag, "_sent"}, idx, 4);
    ordy[k] = 1'b0; iv[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] res;
    logic [127:0] st_a, st_b, hold;
    int           guard, lat;

    for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ist[k] = '0;
    end

    #1;
    check("rst_inrdy_low", ir[2], 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ov", ov[2], 1'b0);
    check("rst_ost", ost[2], 128'h0);
    @(posedge clk); #1;
    check("rel_inrdy", ir[2], 1'b1);

    // All-zero state, B=4.
    run_one(2, 128'h0, "zero", res);
    check("zero_hand", res, {16{8'h52}});

    // Bytes 0..3 = 63,7C,FF,16, rest 00.
    run_one(2, {96'h0, 32'h16FF7C63}, "bytes", res);
    check("bytes_hand", res, {{12{8'h52}}, 32'hFF7D0100});

    // Backpressure in DONE, then simultaneous consume + accept.
    st_a = rand128(); st_b = rand128();
    iv[2] = 1'b1; ist[2] = st_a; ordy[2] = 1'b0;
    @(posedge clk); #1;                         // IDLE: accepted here
    ist[2] = st_b;                              // next state offered, held
    guard = 0;
    while (!ov[2] && guard < 40) begin @(posedge clk); #1; guard++; end
    check("bp_valid", ov[2], 1'b1);
    hold = ost[2];
    check("bp_data", hold, model(st_a));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_stable", ost[2], hold);
      check("bp_inrdy", ir[2], 1'b0);
      check("bp_ov", ov[2], 1'b1);
    end
    ordy[2] = 1'b1;
    #1 check("bp_passthru", ir[2], 1'b1);
    @(posedge clk); #1;                         // consume A, accept B
    iv[2] = 1'b0;
    check("sim_drop", ov[2], 1'b0);
    lat = 0;
    while (!ov[2] && lat < 40) begin @(posedge clk); #1; lat++; end
    check("sim_lat", lat, 5);
    check("sim_data", ost[2], model(st_b));
    @(posedge clk); #1;
    ordy[2] = 1'b0;
    check("sim_idle", ir[2], 1'b1);

    // Back-to-back streams.
    b2b(2, "b2b_b4");
    b2b(4, "b2b_b16");
    b2b(0, "b2b_b1");

    // Sweep all widths with random states.
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 3; r++) begin
        run_one(k, rand128(), $sformatf("sweep_b%0d", BS[k]), res);
      end
    end

    // Reset asserted mid-BUSY.
    iv[2] = 1'b1; ist[2] = rand128();
    @(posedge clk); #1;                         // accept
    iv[2] = 1'b0;
    @(posedge clk); #1;                         // mid-BUSY
    check("mid_ost_before", ost[2] != 128'h0, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_ov", ov[2], 1'b0);
    check("mid_ost", ost[2], 128'h0);
    check("mid_inrdy", ir[2], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rel_inrdy", ir[2], 1'b1);
    for (int c = 0; c < 8; c++) begin
      check("mid_no_partial", ov[2], 1'b0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
